// File: rtl/decode_stage.sv
// decode_stage: instruction decode and operand fetch in front of the ALU.
// Splits a 32-bit instruction into fields, reads a 32x32 register file with
// write-back bypass, extends immediates, and tracks in-flight destinations
// with a pending scoreboard so RAW/WAW hazards stall at the input.
module decode_stage #(
   parameter int NREG = 32,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   output logic            if_ready,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [5:0]      ex_opcode,
   output logic [5:0]      ex_func,
   output logic [XLEN-1:0] ex_opr1,
   output logic [XLEN-1:0] ex_opr2,
   output logic [4:0]      ex_rd,
   output logic            ex_illegal
);

   // instruction fields
   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd_f;
   logic [5:0]  func_f;
   logic [15:0] imm;

   assign opcode = if_instr[31:26];
   assign rs     = if_instr[25:21];
   assign rt     = if_instr[20:16];
   assign rd_f   = if_instr[15:11];
   assign imm    = if_instr[15:0];
   assign func_f = if_instr[5:0];

   // architectural state
   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] pend_q, pend_d;

   // output bundle register
   logic            ex_valid_q, ex_valid_d;
   logic [5:0]      ex_opcode_q, ex_opcode_d;
   logic [5:0]      ex_func_q, ex_func_d;
   logic [XLEN-1:0] ex_opr1_q, ex_opr1_d;
   logic [XLEN-1:0] ex_opr2_q, ex_opr2_d;
   logic [4:0]      ex_rd_q, ex_rd_d;
   logic            ex_illegal_q, ex_illegal_d;

   // decode results
   logic            is_r, legal;
   logic [4:0]      dest;
   logic            busy_rs, busy_rt, busy_dest, hazard;
   logic [XLEN-1:0] rd1, rd2, opr1, opr2, func_out;
   logic            out_free, dispatch;

   // decode, operand read with bypass, hazard detection and handshake
   always_comb begin
      is_r  = (opcode == 6'd0);
      legal = (opcode <= 6'd4);
      dest  = is_r ? rd_f : (legal ? rt : 5'd0);

      // a pending register being written back this cycle is no longer busy
      busy_rs   = pend_q[rs]   && !(wb_en && (wb_addr == rs));
      busy_rt   = pend_q[rt]   && !(wb_en && (wb_addr == rt));
      busy_dest = pend_q[dest] && !(wb_en && (wb_addr == dest));
      hazard    = (legal && busy_rs) || (is_r && busy_rt) ||
                  ((dest != 5'd0) && busy_dest);

      rd1 = (rs == 5'd0) ? '0 : ((wb_en && (wb_addr == rs)) ? wb_data : regs_q[rs]);
      rd2 = (rt == 5'd0) ? '0 : ((wb_en && (wb_addr == rt)) ? wb_data : regs_q[rt]);

      opr1 = legal ? rd1 : '0;
      if (is_r)
         opr2 = rd2;
      else if (!legal)
         opr2 = '0;
      else if (opcode == 6'd4)
         opr2 = {{(XLEN-16){1'b0}}, imm};
      else
         opr2 = {{(XLEN-16){imm[15]}}, imm};
      func_out = is_r ? {{(XLEN-6){1'b0}}, func_f} : '0;

      out_free = !ex_valid_q || ex_ready;
      if_ready = out_free && !hazard;
      dispatch = if_valid && if_ready;
   end

   // next output bundle: load on dispatch, drop valid when drained, else hold
   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_opcode_d  = ex_opcode_q;
      ex_func_d    = ex_func_q;
      ex_opr1_d    = ex_opr1_q;
      ex_opr2_d    = ex_opr2_q;
      ex_rd_d      = ex_rd_q;
      ex_illegal_d = ex_illegal_q;
      if (dispatch) begin
         ex_valid_d   = 1'b1;
         ex_opcode_d  = opcode;
         ex_func_d    = func_out[5:0];
         ex_opr1_d    = opr1;
         ex_opr2_d    = opr2;
         ex_rd_d      = dest;
         ex_illegal_d = !legal;
      end else if (out_free) begin
         ex_valid_d = 1'b0;
      end
   end

   // scoreboard: clear on write-back, set on dispatch (set wins), r0 never pending
   always_comb begin
      pend_d = pend_q;
      if (wb_en)
         pend_d[wb_addr] = 1'b0;
      if (dispatch && (dest != 5'd0))
         pend_d[dest] = 1'b1;
      pend_d[0] = 1'b0;
   end

   // register file entries; r0 is hardwired to zero
   assign regs_d[0] = '0;
   for (genvar gi = 1; gi < NREG; gi++) begin : g_rf
      assign regs_d[gi] = (wb_en && (wb_addr == 5'(gi))) ? wb_data : regs_q[gi];
   end

   // register file storage
   for (genvar gi = 0; gi < NREG; gi++) begin : g_rf_q
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            regs_q[gi] <= '0;
         else
            regs_q[gi] <= regs_d[gi];
      end
   end

   // output bundle and scoreboard state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q   <= 1'b0;
         ex_opcode_q  <= '0;
         ex_func_q    <= '0;
         ex_opr1_q    <= '0;
         ex_opr2_q    <= '0;
         ex_rd_q      <= '0;
         ex_illegal_q <= 1'b0;
         pend_q       <= '0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_opcode_q  <= ex_opcode_d;
         ex_func_q    <= ex_func_d;
         ex_opr1_q    <= ex_opr1_d;
         ex_opr2_q    <= ex_opr2_d;
         ex_rd_q      <= ex_rd_d;
         ex_illegal_q <= ex_illegal_d;
         pend_q       <= pend_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_opcode  = ex_opcode_q;
   assign ex_func    = ex_func_q;
   assign ex_opr1    = ex_opr1_q;
   assign ex_opr2    = ex_opr2_q;
   assign ex_rd      = ex_rd_q;
   assign ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus for decode_stage, checked
// against a behavioural model of the register file, scoreboard and output.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_valid = 1'b0;
   logic [31:0] if_instr = '0;
   logic        if_ready;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        ex_valid;
   logic        ex_ready = 1'b1;
   logic [5:0]  ex_opcode;
   logic [5:0]  ex_func;
   logic [31:0] ex_opr1;
   logic [31:0] ex_opr2;
   logic [4:0]  ex_rd;
   logic        ex_illegal;

   decode_stage #(.NREG(32), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_opcode(ex_opcode), .ex_func(ex_func),
      .ex_opr1(ex_opr1), .ex_opr2(ex_opr2),
      .ex_rd(ex_rd), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        ill;
   } bundle_t;

   // reference model state
   logic [31:0] rf [32];
   logic        pend [32];
   bundle_t     q [$];
   logic        m_valid = 1'b0;
   logic        obs_ready;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
      logic [31:0] w;
      w = '0;
      w[25:21] = 5'(rs); w[20:16] = 5'(rt); w[15:11] = 5'(rd); w[5:0] = 6'(fn);
      return w;
   endfunction

   function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
      logic [31:0] w;
      w = '0;
      w[31:26] = 6'(op); w[25:21] = 5'(rs); w[20:16] = 5'(rt); w[15:0] = 16'(imm);
      return w;
   endfunction

   // register read as seen by an instruction this cycle (bypass from write-back)
   function automatic logic [31:0] rdreg(input int a);
      if (a == 0) return 32'd0;
      if (wb_en && (int'(wb_addr) == a)) return wb_data;
      return rf[a];
   endfunction

   function automatic logic busy_m(input int a);
      return pend[a] && !(wb_en && (int'(wb_addr) == a));
   endfunction

   function automatic logic hazard_m(input logic [31:0] ins);
      int op, rs, rt, dst;
      op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
      if (op > 4) return 1'b0;
      dst = (op == 0) ? int'(ins[15:11]) : rt;
      return busy_m(rs) || ((op == 0) && busy_m(rt)) || ((dst != 0) && busy_m(dst));
   endfunction

   function automatic bundle_t decode_m(input logic [31:0] ins);
      bundle_t b;
      int op, imm;
      op = int'(ins[31:26]);
      imm = int'(ins[15:0]);
      b.op = ins[31:26]; b.fn = 6'd0; b.a = 32'd0; b.b = 32'd0; b.rd = 5'd0; b.ill = 1'b0;
      if (op == 0) begin
         b.a = rdreg(int'(ins[25:21])); b.b = rdreg(int'(ins[20:16]));
         b.rd = ins[15:11]; b.fn = ins[5:0];
      end else if (op <= 4) begin
         b.a = rdreg(int'(ins[25:21]));
         b.rd = ins[20:16];
         if (op != 4 && imm >= 32768) imm = imm - 65536;
         b.b = 32'(imm);
      end else begin
         b.ill = 1'b1;
      end
      return b;
   endfunction

   // one clock cycle: drive at negedge, check before the edge, advance model
   task automatic step(input logic v, input logic [31:0] ins, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic er);
      logic exp_ready, accept;
      bundle_t b;
      if_valid = v; if_instr = ins; wb_en = we; wb_addr = wa; wb_data = wd; ex_ready = er;
      #1;
      exp_ready = (!m_valid || er) && !hazard_m(ins);
      obs_ready = if_ready;
      chk("if_ready", 32'(if_ready), 32'(exp_ready));
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      if (m_valid && q.size() > 0) begin
         chk("ex_opcode", 32'(ex_opcode), 32'(q[0].op));
         chk("ex_func", 32'(ex_func), 32'(q[0].fn));
         chk("ex_opr1", ex_opr1, q[0].a);
         chk("ex_opr2", ex_opr2, q[0].b);
         chk("ex_rd", 32'(ex_rd), 32'(q[0].rd));
         chk("ex_illegal", 32'(ex_illegal), 32'(q[0].ill));
      end
      if (m_valid && er && q.size() > 0) begin
         $display("xfer op=%0d fn=%0d opr1=%h opr2=%h rd=%0d ill=%0d",
                  q[0].op, q[0].fn, q[0].a, q[0].b, q[0].rd, q[0].ill);
         void'(q.pop_front());
      end
      accept = v && exp_ready;
      b = decode_m(ins);
      if (accept) begin
         q.push_back(b);
         m_valid = 1'b1;
      end else if (!m_valid || er) begin
         m_valid = 1'b0;
      end
      if (we) pend[wa] = 1'b0;
      if (accept && b.rd != 5'd0) pend[b.rd] = 1'b1;
      if (we && wa != 5'd0) rf[wa] = wd;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         rf[i] = '0;
         pend[i] = 1'b0;
      end
      q.delete();
      m_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] ins;
      logic        we, er, v;
      logic [4:0]  wa;
      int          cand [$];

      model_clear();
      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_ex_opr1", ex_opr1, 32'd0);
      chk("rst_ex_opr2", ex_opr2, 32'd0);
      chk("rst_ex_rd", 32'(ex_rd), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_if_ready", 32'(if_ready), 32'd1);

      // basic R-type
      step(1'b0, 32'd0, 1'b1, 5'd1, 32'd5, 1'b1);
      step(1'b0, 32'd0, 1'b1, 5'd2, 32'd7, 1'b1);
      step(1'b1, enc_r(1, 2, 3, 0), 1'b0, 5'd0, 32'd0, 1'b1);
      chk("add_valid", 32'(ex_valid), 32'd1);
      chk("add_opr1", ex_opr1, 32'd5);
      chk("add_opr2", ex_opr2, 32'd7);
      chk("add_func", 32'(ex_func), 32'd0);
      chk("add_rd", 32'(ex_rd), 32'd3);

      // RAW stall on R3, then bypassed write-back releases it
      for (int i = 0; i < 3; i++) begin
         step(1'b1, enc_r(3, 0, 4, 0), 1'b0, 5'd0, 32'd0, 1'b1);
         chk("raw_stall", 32'(obs_ready), 32'd0);
      end
      step(1'b1, enc_r(3, 0, 4, 0), 1'b1, 5'd3, 32'h1234, 1'b1);
      chk("raw_release", 32'(obs_ready), 32'd1);
      chk("raw_bypass", ex_opr1, 32'h1234);

      // back-pressure holds the bypassed bundle
      for (int i = 0; i < 4; i++) begin
         step(1'b1, enc_r(1, 2, 10, 5), 1'b0, 5'd0, 32'd0, 1'b0);
         chk("bp_ready", 32'(obs_ready), 32'd0);
         chk("bp_stable", ex_opr1, 32'h1234);
      end
      step(1'b1, enc_r(1, 2, 10, 5), 1'b0, 5'd0, 32'd0, 1'b1);
      step(1'b1, enc_i(2, 1, 11, 16'h0010), 1'b0, 5'd0, 32'd0, 1'b1);

      // immediate extension
      step(1'b1, enc_i(1, 1, 5, 16'hFFFE), 1'b0, 5'd0, 32'd0, 1'b1);
      chk("sext_opr2", ex_opr2, 32'hFFFFFFFE);
      chk("sext_rd", 32'(ex_rd), 32'd5);
      chk("sext_opr1", ex_opr1, 32'd5);
      step(1'b1, enc_i(4, 0, 6, 16'hFFFE), 1'b0, 5'd0, 32'd0, 1'b1);
      chk("zext_opr2", ex_opr2, 32'h0000FFFE);

      // illegal opcode: no operands, no destination, no pending
      ins = enc_r(1, 2, 7, 9);
      ins[31:26] = 6'h3F;
      step(1'b1, ins, 1'b0, 5'd0, 32'd0, 1'b1);
      chk("ill_flag", 32'(ex_illegal), 32'd1);
      chk("ill_opr1", ex_opr1, 32'd0);
      chk("ill_opr2", ex_opr2, 32'd0);
      chk("ill_rd", 32'(ex_rd), 32'd0);
      step(1'b1, enc_r(7, 7, 8, 0), 1'b0, 5'd0, 32'd0, 1'b1);
      chk("ill_no_pend", 32'(obs_ready), 32'd1);

      // register 0 ignores writes
      step(1'b0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
      step(1'b1, enc_r(0, 0, 12, 0), 1'b0, 5'd0, 32'd0, 1'b1);
      chk("r0_opr1", ex_opr1, 32'd0);
      chk("r0_opr2", ex_opr2, 32'd0);

      // random traffic over a small register window
      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         ins[31:26] = 6'($urandom_range(0, 6));
         ins[25:21] = 5'($urandom_range(0, 7));
         ins[20:16] = 5'($urandom_range(0, 7));
         ins[15:11] = 5'($urandom_range(0, 7));
         v  = 1'($urandom_range(0, 3) != 0);
         er = 1'($urandom_range(0, 3) != 0);
         cand.delete();
         for (int r = 1; r < 8; r++) if (pend[r]) cand.push_back(r);
         we = 1'b0;
         wa = 5'($urandom_range(0, 7));
         if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
            we = 1'b1;
            wa = 5'(cand[$urandom_range(0, cand.size() - 1)]);
         end else if ($urandom_range(0, 3) == 0) begin
            we = 1'b1;
         end
         step(v, ins, we, wa, $urandom, er);
      end
      // drain the output before the reset scenario
      step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
      for (int r = 1; r < 32; r++)
         if (pend[r]) step(1'b0, 32'd0, 1'b1, 5'(r), 32'(r * 3), 1'b1);

      // reset while an instruction is stalled behind a pending register
      step(1'b1, enc_r(0, 0, 9, 0), 1'b0, 5'd0, 32'd0, 1'b0);
      step(1'b1, enc_r(9, 0, 11, 0), 1'b0, 5'd0, 32'd0, 1'b0);
      chk("mid_stall", 32'(obs_ready), 32'd0);
      rst_n = 1'b0;
      if_valid = 1'b0;
      wb_en = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(ex_valid), 32'd0);
      chk("mid_rst_rd", 32'(ex_rd), 32'd0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, enc_r(9, 0, 9, 0), 1'b0, 5'd0, 32'd0, 1'b1);
      chk("post_rst_ready", 32'(obs_ready), 32'd1);
      chk("post_rst_opr1", ex_opr1, 32'd0);
      step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode and operand-fetch stage directly upstream of the ALU. Accepts one 32-bit instruction per cycle over a valid/ready handshake and splits it into opcode, func and register fields. It reads operands from an internal 32x32 register file and sign- or zero-extends immediates. Results go to the ALU through a registered valid/ready output. A per-register pending scoreboard stalls read-after-write (RAW) and write-after-write (WAW) hazards until the result is written back through the write-back port.

## Interface
Parameters:
- NREG, 32, number of architectural registers (address width 5)
- XLEN, 32, data width

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- if_valid  input  1  instruction present
- if_instr  input  32  instruction word
- if_ready  output  1  stage accepts instruction this cycle
- wb_en  input  1  write-back strobe
- wb_addr  input  5  write-back register
- wb_data  input  32  write-back value
- ex_valid  output  1  ALU bundle valid
- ex_ready  input  1  ALU stage accepts bundle
- ex_opcode  output  6  to ALU opcode
- ex_func  output  6  to ALU func
- ex_opr1  output  32  to ALU operand 1
- ex_opr2  output  32  to ALU operand 2
- ex_rd  output  5  destination register, 0 = none
- ex_illegal  output  1  opcode not in 0..4

## Operation
- Instruction fields:
  - opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], func = [5:0], imm = [15:0].
- Opcode 0 (R-type):
  - opr1 = R[rs], opr2 = R[rt], dest = rd.
  - func is passed through unchanged.
- Opcodes 1–4 (I-type):
  - opr1 = R[rs], dest = rt, func = 0.
  - opr2 = sign-extended imm for opcodes 1, 2 and 3.
  - opr2 = zero-extended imm for opcode 4 (nand).
- Opcodes 5–63 (illegal):
  - ex_illegal = 1, opr1 = opr2 = 0, dest = 0.
  - No register reads count toward hazards.
- Register 0 always reads 0. Writes to register 0 are ignored, and it is never marked pending.
- Register file write: on a rising edge with wb_en=1 and wb_addr≠0, R[wb_addr] ← wb_data.
- Read bypass: if wb_en=1 and wb_addr equals a source being read in the same cycle (address ≠ 0), the operand takes wb_data.
- Scoreboard, one pending bit per register:
  - A source register counts as "busy" when its pending bit is set and it is not being written back this cycle (wb_en=0 or wb_addr differs).
  - hazard = a used source is busy, OR dest≠0 and dest is busy (WAW).
  - Sources used: R-type uses rs and rt. I-type uses rs only. Illegal uses none.
  - Pending is set on dispatch when dest≠0.
  - Pending is cleared when wb_en=1 for that address.
  - If set and clear hit the same register in the same cycle, set wins.
- Handshake:
  - out_free = !ex_valid || ex_ready.
  - if_ready = out_free && !hazard.
  - Dispatch (load of the output register) occurs when if_valid && if_ready.
  - If out_free and there is no dispatch, ex_valid ← 0.
  - While ex_valid && !ex_ready, all ex_* outputs hold stable.
- Arithmetic: no carries or overflow. Extension is to XLEN only.

## Timing
- Reset (asynchronous, rst_n=0):
  - ex_valid=0, and all ex_* data outputs 0.
  - All registers 0, all pending bits 0.
  - if_ready follows from these values: 1 once rst_n=1.
- Latency: one cycle from accept (if_valid && if_ready at edge N) to ex_valid=1 after edge N.
- Throughput: one instruction per cycle when there is no hazard and ex_ready=1.
- if_ready is combinational from ex_valid, ex_ready, if_instr, the pending bits and the wb_* inputs. There is no combinational path from if_valid to if_ready.
- Write-back in cycle N makes the value visible to a dependent instruction dispatched in the same cycle N (bypass). The earliest dependent dispatch is therefore the write-back cycle itself.
- Reset asserted mid-stall or mid-transfer discards the in-flight bundle and all pending state immediately. No partial write occurs.

## Test plan
- Reset and basic R-type:
  - Stimulus: release reset; wb writes R1=5, then R2=7; dispatch R-type add (opcode 0, rs=1, rt=2, rd=3, func=0).
  - Required: next cycle ex_valid=1, opr1=5, opr2=7, func=0, ex_rd=3.
- Immediate extension:
  - Stimulus: opcode 1 with imm=0xFFFE and rs=1 (R1=5).
  - Required: opr2=0xFFFFFFFE, ex_rd=rt.
  - Stimulus: opcode 4 with imm=0xFFFE.
  - Required: opr2=0x0000FFFE.
- RAW stall and bypass:
  - Stimulus: dispatch add rd=3, then add rs=3 while holding wb off for 3 cycles.
  - Required: if_ready=0 for those 3 cycles.
  - Stimulus: assert wb_en with wb_addr=3, wb_data=0x1234.
  - Required: dispatch that same cycle with opr1=0x1234.
- Back-pressure:
  - Stimulus: hold ex_ready=0 for 4 cycles with if_valid=1.
  - Required: ex_* outputs stable, if_ready=0, no instruction lost; all later instructions emerge in order after ex_ready=1.
- Illegal opcode and register 0:
  - Stimulus: opcode 0x3F.
  - Required: ex_illegal=1, operands 0, no pending bit set.
  - Stimulus: write R0=0xFFFFFFFF.
  - Required: R0 subsequently reads 0.
- Reset mid-stall:
  - Stimulus: rst_n low while a stalled instruction is pending.
  - Required: ex_valid=0 immediately, all pending bits cleared, and the next instruction dispatches with no stall.
